reg_wb_ctrl: RTL and testbench

- Write-back controller: the producer side of the register file write port.
- Arbitrates results from the single-cycle ALU path and the variable-latency load path.
- Buffers load results in a small in-order queue and drives exactly one registered write (wr_en/wr_addr/wr_data) per cycle into the register file.
- Exports a pending-register mask so issue logic can stall on outstanding load destinations.

---
 rtl/rf_pkg.sv | 12 +
 rtl/wb_fifo.sv | 80 ++++++++
 rtl/reg_wb_ctrl.sv | 90 +++++++++
 tb/tb_reg_wb_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions used by the write-back controller and its queue.
package rf_pkg;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [AW_DEF-1:0] rd;
        logic [DW_DEF-1:0] data;
        logic              live;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order load-result queue; each entry carries a live bit that an ALU write to the same rd clears.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enq,
    input  logic [AW-1:0]                  enq_rd,
    input  logic [DW-1:0]                  enq_data,
    input  logic                           enq_live,
    input  logic                           deq,
    input  logic                           kill_en,
    input  logic [AW-1:0]                  kill_rd,
    output logic [AW-1:0]                  head_rd,
    output logic [DW-1:0]                  head_data,
    output logic                           head_live,
    output logic [$clog2(DEPTH):0]         count,
    output logic [DEPTH-1:0]               live_vec,
    output logic [DEPTH-1:0][AW-1:0]       entry_rd
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             cnt;
    logic [DEPTH-1:0][AW-1:0]  rd_q;
    logic [DEPTH-1:0][DW-1:0]  data_q;
    logic [DEPTH-1:0]          live_q, live_nxt;

    // Dequeue clears first, then the new entry lands, then the kill applies to
    // everything including a same-cycle enqueue.
    always_comb begin
        live_nxt = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (deq && rd_ptr == PW'(i)) live_nxt[i] = 1'b0;
            if (enq && wr_ptr == PW'(i)) begin
                live_nxt[i] = enq_live;
                if (kill_en && enq_rd == kill_rd) live_nxt[i] = 1'b0;
            end else if (kill_en && rd_q[i] == kill_rd) begin
                live_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            live_q <= '0;
        end else begin
            live_q <= live_nxt;
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            unique case ({enq, deq})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_q[wr_ptr]   <= enq_rd;
            data_q[wr_ptr] <= enq_data;
        end
    end

    assign head_rd   = rd_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign head_live = live_q[rd_ptr];
    assign count     = cnt;
    assign live_vec  = live_q;
    assign entry_rd  = rd_q;
endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-back controller: ALU results take the slot immediately, load results
// drain from an in-order queue whenever the ALU is idle.
module reg_wb_ctrl
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [AW-1:0]           alu_rd,
    input  logic [DW-1:0]           alu_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [AW-1:0]           ld_rd,
    input  logic [DW-1:0]           ld_data,
    output logic                    wr_en,
    output logic [AW-1:0]           wr_addr,
    output logic [DW-1:0]           wr_data,
    output logic [NUM_REGS-1:0]     pend_mask,
    output logic [$clog2(DEPTH):0]  q_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     enq, deq;
    logic [AW-1:0]            head_rd;
    logic [DW-1:0]            head_data;
    logic                     head_live;
    logic [CW-1:0]            count;
    logic [DEPTH-1:0]         live_vec;
    logic [DEPTH-1:0][AW-1:0] entry_rd;

    assign alu_ready = 1'b1;
    assign ld_ready  = (count < CW'(DEPTH));
    assign enq       = ld_valid && ld_ready;
    assign deq       = !alu_valid && (count != '0);
    assign q_count   = count;

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .enq       (enq),
        .enq_rd    (ld_rd),
        .enq_data  (ld_data),
        .enq_live  (ld_rd != '0),
        .deq       (deq),
        .kill_en   (alu_valid),
        .kill_rd   (alu_rd),
        .head_rd   (head_rd),
        .head_data (head_data),
        .head_live (head_live),
        .count     (count),
        .live_vec  (live_vec),
        .entry_rd  (entry_rd)
    );

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_vec[i]) pend_mask[entry_rd[i]] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    // Address/data only move on a real write so an idle or squashed slot holds them.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (alu_valid) begin
            wr_en <= (alu_rd != '0);
            if (alu_rd != '0) begin
                wr_addr <= alu_rd;
                wr_data <= alu_data;
            end
        end else if (deq) begin
            wr_en <= head_live;
            if (head_live) begin
                wr_addr <= head_rd;
                wr_data <= head_data;
            end
        end else begin
            wr_en <= 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl with hand-computed expectations.
module tb_reg_wb_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pend_mask;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_wb_ctrl #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pend_mask (pend_mask),
        .q_count   (q_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_chk(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".wr_en"}, 64'(wr_en), 64'(en));
        if (en) begin
            chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(a));
            chk({tag, ".wr_data"}, 64'(wr_data), 64'(d));
        end
    endtask

    initial begin
        rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        tick();
        tick();
        rst = 1'b0;
        // Reset state
        chk("rst.wr_en", 64'(wr_en), 0);
        chk("rst.wr_addr", 64'(wr_addr), 0);
        chk("rst.wr_data", 64'(wr_data), 0);
        chk("rst.pend", 64'(pend_mask), 0);
        chk("rst.qcnt", 64'(q_count), 0);
        chk("rst.ld_ready", 64'(ld_ready), 1);
        chk("alu_ready", 64'(alu_ready), 1);

        // ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 0;
        wr_chk("alu", 1, 5, 32'hDEADBEEF);
        chk("alu.pend", 64'(pend_mask), 0);
        tick();
        chk("idle.wr_en", 64'(wr_en), 0);
        chk("idle.hold_addr", 64'(wr_addr), 5);
        chk("idle.hold_data", 64'(wr_data), 64'hDEADBEEF);

        // Single load
        ld_valid = 1; ld_rd = 7; ld_data = 32'h11;
        tick();
        ld_valid = 0;
        chk("ld.pend7", 64'(pend_mask), 64'h80);
        chk("ld.qcnt", 64'(q_count), 1);
        chk("ld.wr_en_early", 64'(wr_en), 0);
        tick();
        wr_chk("ld.write", 1, 7, 32'h11);
        tick();
        chk("ld.pend_clear", 64'(pend_mask), 0);
        chk("ld.qcnt0", 64'(q_count), 0);
        chk("ld.after", 64'(wr_en), 0);

        // Kill: queued load to r9 superseded by an ALU write to r9
        ld_valid = 1; ld_rd = 9; ld_data = 32'h33;
        alu_valid = 1; alu_rd = 12; alu_data = 32'h44;
        tick();
        ld_valid = 0;
        wr_chk("kill.alu12", 1, 12, 32'h44);
        chk("kill.pend9", 64'(pend_mask), 64'h200);
        alu_rd = 9; alu_data = 32'h22;
        tick();
        alu_valid = 0;
        wr_chk("kill.alu9", 1, 9, 32'h22);
        chk("kill.pend0", 64'(pend_mask), 0);
        chk("kill.qcnt1", 64'(q_count), 1);
        tick();
        chk("kill.deq_wr_en", 64'(wr_en), 0);
        chk("kill.hold_data", 64'(wr_data), 64'h22);
        chk("kill.qcnt0", 64'(q_count), 0);
        tick();
        chk("kill.quiet", 64'(wr_en), 0);

        // Fill queue behind a busy ALU
        alu_valid = 1; alu_rd = 20; alu_data = 32'h99;
        for (int i = 1; i <= 4; i++) begin
            ld_valid = 1; ld_rd = 5'(i); ld_data = 32'hA0 + 32'(i);
            tick();
        end
        chk("full.ld_ready", 64'(ld_ready), 0);
        chk("full.qcnt", 64'(q_count), 4);
        chk("full.pend", 64'(pend_mask), 64'h1E);
        ld_rd = 5; ld_data = 32'hA5;
        tick();
        chk("full.held_qcnt", 64'(q_count), 4);
        chk("full.held_ready", 64'(ld_ready), 0);
        wr_chk("full.alu", 1, 20, 32'h99);
        alu_valid = 0;
        tick();
        wr_chk("drain.1", 1, 1, 32'hA1);
        chk("drain.ld_ready", 64'(ld_ready), 1);
        chk("drain.qcnt3", 64'(q_count), 3);
        tick();
        ld_valid = 0;
        wr_chk("drain.2", 1, 2, 32'hA2);
        chk("drain.qcnt_enq", 64'(q_count), 3);
        tick();
        wr_chk("drain.3", 1, 3, 32'hA3);
        tick();
        wr_chk("drain.4", 1, 4, 32'hA4);
        chk("drain.pend5", 64'(pend_mask), 64'h20);
        tick();
        wr_chk("drain.5", 1, 5, 32'hA5);
        tick();
        chk("drain.end", 64'(wr_en), 0);
        chk("drain.qcnt0", 64'(q_count), 0);

        // x0 on both paths
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1;
        ld_valid = 1; ld_rd = 0; ld_data = 32'h2;
        tick();
        alu_valid = 0; ld_valid = 0;
        chk("x0.alu_wr_en", 64'(wr_en), 0);
        chk("x0.qcnt1", 64'(q_count), 1);
        chk("x0.pend", 64'(pend_mask), 0);
        tick();
        chk("x0.ld_wr_en", 64'(wr_en), 0);
        chk("x0.qcnt0", 64'(q_count), 0);
        tick();
        chk("x0.quiet", 64'(wr_en), 0);

        // Reset with queued loads
        alu_valid = 1; alu_rd = 0; alu_data = 0;
        for (int i = 10; i <= 12; i++) begin
            ld_valid = 1; ld_rd = 5'(i); ld_data = 32'hB0 + 32'(i);
            tick();
        end
        ld_valid = 0;
        chk("mrst.qcnt3", 64'(q_count), 3);
        chk("mrst.pend", 64'(pend_mask), 64'h1C00);
        alu_valid = 0; rst = 1;
        tick();
        rst = 0;
        chk("mrst.qcnt0", 64'(q_count), 0);
        chk("mrst.pend0", 64'(pend_mask), 0);
        chk("mrst.wr_en", 64'(wr_en), 0);
        chk("mrst.ld_ready", 64'(ld_ready), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mrst.no_write", 64'(wr_en), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
